sram_burst_reader: RTL and testbench
====================================

# sram_burst_reader

Read-side initiator for the 8192x16 banked SRAM wrapper. It accepts a burst command (start address, word count) and issues one read per cycle on the active-low read port, absorbing the wrapper's fixed 1-cycle read latency. Returned words go out on a valid/ready stream through a 2-entry skid FIFO, so consumer backpressure never loses data. It sits between the PE-array feeders and the activation/weight SRAM banks.

## Interface
- nb_data, 8192, SRAM depth in words
- L_data, 16, word width
- L_addr, clogb2(nb_data), address width (13 at default)

- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  burst command present
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  L_addr  first word address
- cmd_len  in  L_addr+1  word count, 0..nb_data
- rEn  out  1  SRAM read enable, active-low
- rAddr  out  L_addr  SRAM read address
- rData  in  L_data  SRAM read data, valid 1 cycle after rEn=0
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  L_data  returned word, address order
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at burst completion

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1. A handshake latches addr_q=cmd_addr and remain=min(cmd_len, nb_data).
  - remain>0: go to RUN.
  - cmd_len=0: stay IDLE and pulse done the next cycle.
- RUN: cmd_ready=0. Issue when occ + inflight − pop < 2.
  - occ = FIFO occupancy (0..2); inflight = read issued last cycle; pop = out_valid && out_ready.
  - Issue: rEn=0, rAddr=addr_q, addr_q+1 (wraps nb_data−1 → 0), remain−1.
  - After the last issue, go to DRAIN.
- DRAIN: no issues. When occ=0, inflight=0 and no push pending, go to IDLE and pulse done.
- rData is pushed into the FIFO in the cycle after each issue, unconditionally. The FIFO can never overflow because of the issue rule.
- Simultaneous push and pop on a full or one-entry FIFO is legal; occupancy is unchanged.
- rEn=1 whenever not issuing. rAddr holds its last value when rEn=1.
- out_data is stable while out_valid && !out_ready.
- busy = (state≠IDLE).

## Timing
- Reset values:
  - cmd_ready=0 during rst, 1 the cycle after.
  - rEn=1, rAddr=0, out_valid=0, out_data=0, busy=0, done=0.
  - FIFO empty, inflight=0.
- Command accept to first rEn=0: 1 cycle.
- rEn=0 to word in FIFO: 1 cycle; to out_valid: 2 cycles after issue.
- With out_ready held high: 1 word/cycle sustained. A burst of N finishes with done at cycle accept+N+3.
- With out_ready low: at most 2 words are buffered and issue stalls. Issue resumes in the same cycle out_ready rises.
- rst mid-burst: state→IDLE, FIFO cleared, inflight cleared. rData arriving the cycle after reset is discarded. No done pulse.

## Configuration
- SRAM_BURST_RD_STALL_CNT_EN defined:
  - Adds output stall_cnt (16 bits): counts cycles with out_valid && !out_ready.
  - Saturates at 0xFFFF. Cleared on rst and on each command accept.
- Undefined: no port, no counter logic; all other behaviour is identical.

## Test plan
- Preload mem[i]=i. Command addr=0x10, len=4, out_ready=1 → rEn low for 4 consecutive cycles (rAddr 0x10..0x13); out_data 0x10..0x13 on consecutive cycles; done at accept+7.
- Command addr=0x1FFE, len=4 → rAddr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001; data in the same order.
- Command len=8, out_ready low for cycles 3..10 → exactly 2 words buffered, no rEn=0 while stalled, all 8 words delivered in order, none lost or duplicated; stall_cnt=8 when the macro is defined.
- Command len=0 → cmd_ready stays 1, rEn never low, done pulses once; cmd_len=9000 → exactly 8192 words delivered.
- Assert rst the cycle after the 3rd issue of a len=16 burst → next cycle out_valid=0, busy=0, rEn=1; no done pulse; a new len=2 burst then returns the correct 2 words.

Source files
------------

// File: rtl/sram_burst_reader_if.sv
// Bundle of signals between sram_burst_reader and its neighbours.
//   cmd_*     : burst command handshake (start address, word count)
//   rEn/rAddr : active-low SRAM read request; rData returns one cycle later
//   out_*     : valid/ready stream of returned words, address order
//   busy/done : burst status; done pulses for one cycle at completion
//   stall_cnt : only with SRAM_BURST_RD_STALL_CNT_EN defined
// slave  : view taken by sram_burst_reader
// master : view taken by the command issuer / SRAM model / consumer
interface sram_burst_reader_if #(
    parameter int unsigned nb_data = 8192,
    parameter int unsigned L_data  = 16
);
    localparam int unsigned L_addr = $clog2(nb_data);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [L_addr-1:0] cmd_addr;
    logic [L_addr:0]   cmd_len;
    logic              rEn;
    logic [L_addr-1:0] rAddr;
    logic [L_data-1:0] rData;
    logic              out_valid;
    logic              out_ready;
    logic [L_data-1:0] out_data;
    logic              busy;
    logic              done;

`ifdef SRAM_BURST_RD_STALL_CNT_EN
    logic [15:0]       stall_cnt;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, rData, out_ready,
        output cmd_ready, rEn, rAddr, out_valid, out_data, busy, done, stall_cnt
    );
    modport master (
        output cmd_valid, cmd_addr, cmd_len, rData, out_ready,
        input  cmd_ready, rEn, rAddr, out_valid, out_data, busy, done, stall_cnt
    );
`else
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, rData, out_ready,
        output cmd_ready, rEn, rAddr, out_valid, out_data, busy, done
    );
    modport master (
        output cmd_valid, cmd_addr, cmd_len, rData, out_ready,
        input  cmd_ready, rEn, rAddr, out_valid, out_data, busy, done
    );
`endif
endinterface

// File: rtl/sram_burst_reader.sv
// Read-side burst initiator for the banked SRAM wrapper. Takes a command
// (start address, word count), issues one active-low read per cycle while a
// 2-entry skid FIFO has room for everything in flight, absorbs the 1-cycle
// SRAM read latency and streams the words out on valid/ready.
// Ports:
//   clk  : clock, posedge
//   rst  : synchronous active-high reset
//   bus  : sram_burst_reader_if.slave (cmd_*, rEn/rAddr/rData, out_*, busy, done)
// Optional: SRAM_BURST_RD_STALL_CNT_EN adds bus.stall_cnt, a saturating
// count of cycles with out_valid && !out_ready, cleared per command.
module sram_burst_reader #(
    parameter int unsigned nb_data = 8192,
    parameter int unsigned L_data  = 16
) (
    input  logic               clk,
    input  logic               rst,
    sram_burst_reader_if.slave bus
);
    localparam int unsigned L_addr = $clog2(nb_data);
    localparam int unsigned L_len  = L_addr + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [L_addr-1:0] addr_q;
    logic [L_addr-1:0] raddr_q;
    logic [L_len-1:0]  remain_q;
    logic              inflight_q;
    logic              done_q;
    logic [L_data-1:0] fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;

    logic              accept_c;
    logic              pop_c;
    logic              issue_c;
    logic              last_c;
    logic [1:0]        occ_d;
    logic [L_addr-1:0] addr_inc_c;
    logic [L_len-1:0]  len_clip_c;

    // Issue only when the FIFO can hold this read plus the one already in flight.
    always_comb begin
        accept_c   = 1'b0;
        pop_c      = 1'b0;
        issue_c    = 1'b0;
        last_c     = 1'b0;
        occ_d      = occ_q;
        addr_inc_c = addr_q + L_addr'(1);
        len_clip_c = bus.cmd_len;

        accept_c = !rst && (state_q == IDLE) && bus.cmd_valid;
        pop_c    = (occ_q != 2'd0) && bus.out_ready;
        issue_c  = !rst && (state_q == RUN)
                   && ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_c)));
        last_c   = issue_c && (remain_q == L_len'(1));
        occ_d    = occ_q + 2'(inflight_q) - 2'(pop_c);

        if (addr_q == L_addr'(nb_data - 1)) begin
            addr_inc_c = '0;
        end
        if (bus.cmd_len > L_len'(nb_data)) begin
            len_clip_c = L_len'(nb_data);
        end
    end

    // FSM, address/length tracking and skid FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            raddr_q    <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue_c;
            occ_q      <= occ_d;

            // Read data lands one cycle after issue and is always accepted.
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= bus.rData;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (issue_c) begin
                raddr_q  <= addr_q;
                addr_q   <= addr_inc_c;
                remain_q <= remain_q - L_len'(1);
            end

            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        addr_q   <= bus.cmd_addr;
                        remain_q <= len_clip_c;
                        if (len_clip_c == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_c) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish once the FIFO will be empty with nothing still arriving.
                    if ((occ_d == 2'd0) && !inflight_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SRAM_BURST_RD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating backpressure counter, restarted by each command.
    always_ff @(posedge clk) begin
        if (rst || accept_c) begin
            stall_cnt_q <= '0;
        end else if ((occ_q != 2'd0) && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

    // rEn/rAddr follow the same-cycle issue decision so issue can resume as
    // soon as out_ready rises; rAddr holds the last issued address otherwise.
    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign bus.rEn       = ~issue_c;
    assign bus.rAddr     = issue_c ? addr_q : raddr_q;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = fifo_q[rd_ptr_q];
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a 1-cycle-latency SRAM model
// preloaded with mem[i] = i.
module tb_sram_burst_reader;
    localparam int unsigned NB = 8192;
    localparam int unsigned LD = 16;
    localparam int unsigned LA = 13;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sram_burst_reader_if #(.nb_data(NB), .L_data(LD)) bus ();
    sram_burst_reader #(.nb_data(NB), .L_data(LD)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [LD-1:0] mem [NB];

    always_ff @(posedge clk) begin
        if (!bus.rEn) bus.rData <= mem[bus.rAddr];
    end

    // Per-cycle log sampled mid-cycle.
    int            cyc      = 0;
    int            acc_cyc  = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    logic [LA-1:0] iss_addr [$];
    int            iss_cyc  [$];
    logic [LD-1:0] dat      [$];
    int            dat_cyc  [$];

    always @(negedge clk) begin
        if (!rst && bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
        if (!rst && !bus.rEn) begin
            iss_addr.push_back(bus.rAddr);
            iss_cyc.push_back(cyc);
        end
        if (!rst && bus.out_valid && bus.out_ready) begin
            dat.push_back(bus.out_data);
            dat_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    task automatic send_cmd(input logic [LA-1:0] a, input logic [LA:0] n);
        int w;
        w = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = n;
        while (!bus.cmd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if (w >= 50) begin
            n_err++;
            $display("FAIL cmd_accept got no cmd_ready exp ready within 50 cycles");
        end
    endtask

    task automatic wait_done(input int dc, input int budget);
        int w;
        w = 0;
        while (done_cnt == dc && w < budget) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++;
        if (done_cnt == dc) begin
            n_err++;
            $display("FAIL done_timeout got no done exp pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready got %b exp 0", bus.cmd_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_cmd_ready got %b exp 1", bus.cmd_ready); end
        n_cmp++; if (bus.rEn !== 1'b1)       begin n_err++; $display("FAIL rst_rEn got %b exp 1", bus.rEn); end
        n_cmp++; if (bus.rAddr !== '0)       begin n_err++; $display("FAIL rst_rAddr got %h exp 0", bus.rAddr); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== '0)    begin n_err++; $display("FAIL rst_out_data got %h exp 0", bus.out_data); end
        n_cmp++; if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)      begin n_err++; $display("FAIL rst_done got %b exp 0", bus.done); end
    endtask

    // 4-word burst with out_ready high: issues at accept+1.., data at accept+3.., done at accept+7.
    task automatic test_burst(input string tag, input logic [LA-1:0] a0);
        int ib, db, dc, gc;
        logic [LA-1:0] ea, ga;
        logic [LD-1:0] gd;
        ib = iss_addr.size(); db = dat.size(); dc = done_cnt;
        bus.out_ready = 1'b1;
        send_cmd(a0, 14'd4);
        wait_done(dc, 40);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (iss_addr.size() - ib !== 4) begin
            n_err++; $display("FAIL %s_issue_count got %0d exp 4", tag, iss_addr.size() - ib);
        end
        for (int k = 0; k < 4; k++) begin
            ea = a0 + LA'(k);
            ga = (ib + k < iss_addr.size()) ? iss_addr[ib + k] : 'x;
            gc = (ib + k < iss_cyc.size()) ? iss_cyc[ib + k] : -1;
            n_cmp++; if (ga !== ea) begin n_err++; $display("FAIL %s_rAddr%0d got %h exp %h", tag, k, ga, ea); end
            n_cmp++; if (gc !== acc_cyc + 1 + k) begin n_err++; $display("FAIL %s_issue_cyc%0d got %0d exp %0d", tag, k, gc, acc_cyc + 1 + k); end
            gd = (db + k < dat.size()) ? dat[db + k] : 'x;
            gc = (db + k < dat_cyc.size()) ? dat_cyc[db + k] : -1;
            n_cmp++; if (gd !== LD'(ea)) begin n_err++; $display("FAIL %s_data%0d got %h exp %h", tag, k, gd, LD'(ea)); end
            n_cmp++; if (gc !== acc_cyc + 3 + k) begin n_err++; $display("FAIL %s_data_cyc%0d got %0d exp %0d", tag, k, gc, acc_cyc + 3 + k); end
        end
        n_cmp++; if (done_cnt - dc !== 1) begin n_err++; $display("FAIL %s_done_count got %0d exp 1", tag, done_cnt - dc); end
        n_cmp++; if (done_cyc !== acc_cyc + 7) begin n_err++; $display("FAIL %s_done_cyc got %0d exp %0d", tag, done_cyc, acc_cyc + 7); end
    endtask

    // out_ready low for accept+3..accept+10: issues at +1,+2 then +11..+16; done at +19.
    task automatic test_stall();
        int ib, db, dc, n_pre, n_win, first_after, n_pop_pre;
        logic [LD-1:0] gd;
        ib = iss_addr.size(); db = dat.size(); dc = done_cnt;
        n_pre = 0; n_win = 0; first_after = -1; n_pop_pre = 0;
        bus.out_ready = 1'b1;
        send_cmd(13'h0300, 14'd8);
        for (int c = 1; c <= 40 && done_cnt == dc; c++) begin
            bus.out_ready = !(c >= 3 && c <= 10);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        n_cmp++; if (done_cnt - dc !== 1) begin n_err++; $display("FAIL stall_done_count got %0d exp 1", done_cnt - dc); end
        for (int i = ib; i < iss_cyc.size(); i++) begin
            if (iss_cyc[i] < acc_cyc + 11) n_pre++;
            if (iss_cyc[i] >= acc_cyc + 3 && iss_cyc[i] <= acc_cyc + 10) n_win++;
            if (iss_cyc[i] >= acc_cyc + 11 && first_after < 0) first_after = iss_cyc[i];
        end
        for (int i = db; i < dat_cyc.size(); i++) begin
            if (dat_cyc[i] < acc_cyc + 11) n_pop_pre++;
        end
        n_cmp++; if (n_pre !== 2) begin n_err++; $display("FAIL stall_buffered got %0d exp 2", n_pre); end
        n_cmp++; if (n_win !== 0) begin n_err++; $display("FAIL stall_issue_in_window got %0d exp 0", n_win); end
        n_cmp++; if (n_pop_pre !== 0) begin n_err++; $display("FAIL stall_pop_in_window got %0d exp 0", n_pop_pre); end
        n_cmp++; if (first_after !== acc_cyc + 11) begin n_err++; $display("FAIL stall_resume_cyc got %0d exp %0d", first_after, acc_cyc + 11); end
        n_cmp++; if (iss_addr.size() - ib !== 8) begin n_err++; $display("FAIL stall_issue_count got %0d exp 8", iss_addr.size() - ib); end
        n_cmp++; if (dat.size() - db !== 8) begin n_err++; $display("FAIL stall_word_count got %0d exp 8", dat.size() - db); end
        for (int k = 0; k < 8; k++) begin
            gd = (db + k < dat.size()) ? dat[db + k] : 'x;
            n_cmp++; if (gd !== LD'(16'h0300 + k)) begin n_err++; $display("FAIL stall_data%0d got %h exp %h", k, gd, LD'(16'h0300 + k)); end
        end
        n_cmp++; if (done_cyc !== acc_cyc + 19) begin n_err++; $display("FAIL stall_done_cyc got %0d exp %0d", done_cyc, acc_cyc + 19); end
`ifdef SRAM_BURST_RD_STALL_CNT_EN
        n_cmp++; if (bus.stall_cnt !== 16'd8) begin n_err++; $display("FAIL stall_cnt got %0d exp 8", bus.stall_cnt); end
`endif
    endtask

    task automatic test_zero_len();
        int ib, dc;
        ib = iss_addr.size(); dc = done_cnt;
        send_cmd(13'h0020, 14'd0);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL zero_cmd_ready got %b exp 1", bus.cmd_ready); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL zero_cmd_ready_late got %b exp 1", bus.cmd_ready); end
        n_cmp++; if (iss_addr.size() - ib !== 0) begin n_err++; $display("FAIL zero_issues got %0d exp 0", iss_addr.size() - ib); end
        n_cmp++; if (done_cnt - dc !== 1) begin n_err++; $display("FAIL zero_done_count got %0d exp 1", done_cnt - dc); end
        n_cmp++; if (done_cyc !== acc_cyc + 1) begin n_err++; $display("FAIL zero_done_cyc got %0d exp %0d", done_cyc, acc_cyc + 1); end
    endtask

    // cmd_len above depth is clipped to 8192 words.
    task automatic test_max_len();
        int ib, db, dc, bad;
        logic [LA-1:0] ea;
        ib = iss_addr.size(); db = dat.size(); dc = done_cnt; bad = 0;
        bus.out_ready = 1'b1;
        send_cmd(13'h0100, 14'd9000);
        wait_done(dc, 9000);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dat.size() - db !== 8192) begin n_err++; $display("FAIL max_word_count got %0d exp 8192", dat.size() - db); end
        n_cmp++; if (iss_addr.size() - ib !== 8192) begin n_err++; $display("FAIL max_issue_count got %0d exp 8192", iss_addr.size() - ib); end
        for (int k = 0; k < 8192 && db + k < dat.size(); k++) begin
            ea = 13'h0100 + LA'(k);
            if (dat[db + k] !== LD'(ea)) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL max_data_errors got %0d exp 0", bad); end
        n_cmp++; if (done_cyc !== acc_cyc + 8195) begin n_err++; $display("FAIL max_done_cyc got %0d exp %0d", done_cyc, acc_cyc + 8195); end
    endtask

    task automatic test_reset_mid();
        int ib, db, dc;
        logic [LD-1:0] gd;
        ib = iss_addr.size(); dc = done_cnt;
        bus.out_ready = 1'b1;
        send_cmd(13'h0040, 14'd16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_cmd_ready got %b exp 0", bus.cmd_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got %b exp 0", bus.out_valid); end
        n_cmp++; if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
        n_cmp++; if (bus.rEn !== 1'b1)       begin n_err++; $display("FAIL mid_rEn got %b exp 1", bus.rEn); end
        n_cmp++; if (iss_addr.size() - ib !== 3) begin n_err++; $display("FAIL mid_issue_count got %0d exp 3", iss_addr.size() - ib); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt - dc !== 0) begin n_err++; $display("FAIL mid_no_done got %0d exp 0", done_cnt - dc); end
        db = dat.size(); dc = done_cnt;
        send_cmd(13'h0200, 14'd2);
        wait_done(dc, 20);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dat.size() - db !== 2) begin n_err++; $display("FAIL mid_new_count got %0d exp 2", dat.size() - db); end
        for (int k = 0; k < 2; k++) begin
            gd = (db + k < dat.size()) ? dat[db + k] : 'x;
            n_cmp++; if (gd !== LD'(16'h0200 + k)) begin n_err++; $display("FAIL mid_new_data%0d got %h exp %h", k, gd, LD'(16'h0200 + k)); end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NB); i++) mem[i] = LD'(i);
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;

        test_reset();
        test_burst("basic", 13'h0010);
        test_burst("wrap", 13'h1FFE);
        test_stall();
        test_zero_len();
        test_max_len();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
